// File: rtl/hazard_tracker.sv
// hazard_tracker: per-stage writer scoreboard driving D-stage stall and forwarding select.
// Optional MDU busy tracking is enabled by defining HAZARD_MDU_EN.
module hazard_tracker #(
    parameter int NSTAGE   = 3,
    parameter int RW       = 5,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            d_valid,
    input  logic [RW-1:0]                   d_rs,
    input  logic [RW-1:0]                   d_rt,
    input  logic [TW-1:0]                   d_tuse_rs,
    input  logic [TW-1:0]                   d_tuse_rt,
    input  logic [RW-1:0]                   d_dst,
    input  logic [TW-1:0]                   d_tnew,
    input  logic                            d_md,
    input  logic                            d_md_div,
    input  logic                            d_mdu_use,
    input  logic                            flush,
    output logic                            stall,
    output logic [$clog2(NSTAGE+1)-1:0]     fwd_rs_sel,
    output logic [$clog2(NSTAGE+1)-1:0]     fwd_rt_sel,
    output logic                            mdu_busy
);

    localparam int SW = $clog2(NSTAGE + 1);
    localparam logic [TW-1:0] TUSE_NONE = '1;

    logic [NSTAGE:1][RW-1:0] dst_q, dst_d;
    logic [NSTAGE:1][TW-1:0] tnew_q, tnew_d;
    logic [NSTAGE:1]         md_q, md_d;

    logic          rs_live, rt_live;
    logic          hit_rs, hit_rt;
    logic [TW-1:0] tn_rs, tn_rt;
    logic [SW-1:0] k_rs, k_rt;
    logic          stall_rs, stall_rt, stall_mdu;

    assign rs_live = (d_rs != '0) && (d_tuse_rs != TUSE_NONE);
    assign rt_live = (d_rt != '0) && (d_tuse_rt != TUSE_NONE);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        tn_rs  = '0;
        tn_rt  = '0;
        k_rs   = '0;
        k_rt   = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (rs_live && dst_q[k] == d_rs) begin
                hit_rs = 1'b1;
                tn_rs  = tnew_q[k];
                k_rs   = SW'(k);
            end
            if (rt_live && dst_q[k] == d_rt) begin
                hit_rt = 1'b1;
                tn_rt  = tnew_q[k];
                k_rt   = SW'(k);
            end
        end
    end

    assign stall_rs = hit_rs && (tn_rs > d_tuse_rs);
    assign stall_rt = hit_rt && (tn_rt > d_tuse_rt);

    assign fwd_rs_sel = (hit_rs && tn_rs == '0) ? k_rs : '0;
    assign fwd_rt_sel = (hit_rt && tn_rt == '0) ? k_rt : '0;

    assign stall = d_valid & (stall_rs | stall_rt | stall_mdu)
                 & ~reset & ~flush;

    always_comb begin
        dst_d  = '0;
        tnew_d = '0;
        md_d   = '0;
        if (!flush) begin
            for (int k = NSTAGE; k >= 2; k--) begin
                dst_d[k]  = dst_q[k-1];
                md_d[k]   = md_q[k-1];
                tnew_d[k] = (tnew_q[k-1] == '0) ? '0
                          : tnew_q[k-1] - TW'(1);
            end
            if (d_valid && !stall) begin
                dst_d[1]  = d_dst;
                tnew_d[1] = d_tnew;
                md_d[1]   = d_md;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dst_q  <= '0;
            tnew_q <= '0;
            md_q   <= '0;
        end else begin
            dst_q  <= dst_d;
            tnew_q <= tnew_d;
            md_q   <= md_d;
        end
    end

`ifdef HAZARD_MDU_EN
    localparam int CMAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          md_accept;
    logic          unused_md;

    assign md_accept = d_valid & d_md & ~stall & ~flush;

    // Flush leaves the counter alone: the MDU op has already issued.
    always_comb begin
        cnt_d = cnt_q;
        if (md_accept) begin
            cnt_d = d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mdu_busy  = (cnt_q != '0);
    assign stall_mdu = d_mdu_use & (mdu_busy | md_q[1]);
    assign unused_md = md_q[NSTAGE];
`else
    logic unused_md;

    assign mdu_busy  = 1'b0;
    assign stall_mdu = 1'b0;
    assign unused_md = ^{d_md_div, d_mdu_use, md_q};
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed scenarios plus random traffic against
// an age-based reference model of in-flight writers.
module tb_hazard_tracker;

    localparam int NSTAGE   = 3;
    localparam int RW       = 5;
    localparam int TW       = 2;
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;
`ifdef HAZARD_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, d_valid, flush;
    logic [RW-1:0] d_rs, d_rt, d_dst;
    logic [TW-1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic          d_md, d_md_div, d_mdu_use;
    logic          stall, mdu_busy;
    logic [1:0]    fwd_rs_sel, fwd_rt_sel;

    always #5 clk = ~clk;

    hazard_tracker #(
        .NSTAGE(NSTAGE), .RW(RW), .TW(TW),
        .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)
    ) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid),
        .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_dst(d_dst), .d_tnew(d_tnew),
        .d_md(d_md), .d_md_div(d_md_div), .d_mdu_use(d_mdu_use),
        .flush(flush), .stall(stall),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .mdu_busy(mdu_busy)
    );

    // Each accepted writer is remembered with the cycle it left D.
    typedef struct {
        int dst;
        int tnew;
        bit md;
        int cyc;
    } wr_t;

    wr_t q[$];
    int  cyc = 0;
    int  md_acc = -1000;
    int  md_len = 0;
    int  ntot = 0, npass = 0, nfail = 0;
    bit  exp_stall;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        ntot++;
        assert (obs === expv) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic void lookup(input int src, input int tuse,
                                   output bit st, output int sel);
        st  = 1'b0;
        sel = 0;
        if (src == 0 || tuse == 3) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            int age;
            int rem;
            age = cyc - q[i].cyc;
            if (age < 1 || age > NSTAGE) continue;
            if (q[i].dst == src) begin
                rem = q[i].tnew - (age - 1);
                if (rem < 0) rem = 0;
                st  = (rem > tuse);
                sel = (rem == 0) ? age : 0;
                return;
            end
        end
    endfunction

    task automatic settle();
        bit s_rs, s_rt, busy, md1, s_mdu;
        int sel_rs, sel_rt;
        @(negedge clk);
        lookup(int'(d_rs), int'(d_tuse_rs), s_rs, sel_rs);
        lookup(int'(d_rt), int'(d_tuse_rt), s_rt, sel_rt);
        md1 = 1'b0;
        foreach (q[i]) if (q[i].md && cyc - q[i].cyc == 1) md1 = 1'b1;
        busy  = MDU && (cyc - md_acc >= 1) && (cyc - md_acc <= md_len);
        s_mdu = MDU && d_mdu_use && (busy || md1);
        exp_stall = d_valid && (s_rs || s_rt || s_mdu) && !reset && !flush;
        chk("stall", stall, exp_stall);
        chk("fwd_rs_sel", fwd_rs_sel, sel_rs);
        chk("fwd_rt_sel", fwd_rt_sel, sel_rt);
        chk("mdu_busy", mdu_busy, busy);
    endtask

    task automatic advance();
        if (reset || flush) begin
            q.delete();
            if (reset) md_acc = -1000;
        end else if (d_valid && !exp_stall) begin
            q.push_back('{int'(d_dst), int'(d_tnew), d_md, cyc});
            if (MDU && d_md) begin
                md_acc = cyc;
                md_len = d_md_div ? DIV_CYC : MULT_CYC;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        while (q.size() > 0 && cyc - q[0].cyc > NSTAGE) void'(q.pop_front());
    endtask

    task automatic put(input bit v, input int rs, input int trs,
                       input int rt, input int trt,
                       input int dst, input int tn);
        d_valid   = v;
        d_rs      = RW'(rs);
        d_tuse_rs = TW'(trs);
        d_rt      = RW'(rt);
        d_tuse_rt = TW'(trt);
        d_dst     = RW'(dst);
        d_tnew    = TW'(tn);
        d_md      = 1'b0;
        d_md_div  = 1'b0;
        d_mdu_use = 1'b0;
        flush     = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic idle(input int n);
        put(0, 0, 3, 0, 3, 0, 0);
        repeat (n) begin
            settle();
            advance();
        end
    endtask

    initial begin
        int n_st, n_b;
        put(0, 0, 3, 0, 3, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        settle();
        chk("reset_stall", stall, 0);
        chk("reset_sel", fwd_rs_sel, 0);
        chk("reset_busy", mdu_busy, 0);
        advance();
        idle(1);

        // load $2 then dependent add
        put(1, 0, 3, 0, 3, 2, 2);
        settle(); advance();
        put(1, 2, 1, 0, 3, 4, 1);
        settle(); chk("lu_stall", stall, 1); advance();
        settle(); chk("lu_release", stall, 0);
        chk("lu_sel_wait", fwd_rs_sel, 0); advance();
        put(0, 2, 0, 0, 3, 0, 0);
        settle(); chk("lu_sel_w", fwd_rs_sel, 3); advance();
        idle(3);

        // ALU chain, add then beq
        put(1, 0, 3, 0, 3, 3, 1);
        settle(); advance();
        put(1, 0, 3, 3, 1, 0, 0);
        settle(); chk("alu_stall", stall, 0);
        chk("alu_sel", fwd_rt_sel, 0); advance();
        idle(3);
        put(1, 0, 3, 0, 3, 3, 1);
        settle(); advance();
        put(1, 0, 3, 3, 0, 0, 0);
        settle(); chk("beq_stall", stall, 1); advance();
        settle(); chk("beq_release", stall, 0);
        chk("beq_sel_m", fwd_rt_sel, 2); advance();
        idle(3);

        // youngest writer wins
        put(1, 0, 3, 0, 3, 5, 1);
        settle(); advance();
        settle(); advance();
        put(1, 5, 0, 0, 3, 0, 0);
        settle(); chk("young_stall", stall, 1);
        chk("young_sel", fwd_rs_sel, 0); advance();
        idle(3);

        // $0 and unused sources
        put(1, 0, 3, 0, 3, 0, 2);
        settle(); advance();
        put(1, 0, 1, 0, 0, 0, 0);
        settle(); chk("zero_stall", stall, 0);
        chk("zero_sel", fwd_rs_sel, 0); advance();
        put(1, 0, 3, 0, 3, 6, 2);
        settle(); advance();
        put(1, 6, 3, 6, 3, 0, 0);
        settle(); chk("unused_stall", stall, 0);
        chk("unused_sel", fwd_rt_sel, 0); advance();
        idle(3);

        // flush kills records
        put(1, 0, 3, 0, 3, 7, 2);
        settle(); advance();
        put(1, 7, 0, 0, 3, 0, 0);
        flush = 1'b1;
        settle(); chk("flush_stall", stall, 0); advance();
        put(1, 7, 0, 0, 3, 0, 0);
        settle(); chk("post_flush_stall", stall, 0);
        chk("post_flush_sel", fwd_rs_sel, 0); advance();
        idle(3);

        // div then back-to-back mflo
        put(1, 0, 3, 0, 3, 0, 0);
        d_md = 1'b1; d_md_div = 1'b1; d_mdu_use = 1'b1;
        settle(); chk("div_stall", stall, 0); advance();
        put(1, 0, 3, 0, 3, 8, 1);
        d_mdu_use = 1'b1;
        n_st = 0;
        n_b  = 0;
        repeat (20) begin
            settle();
            n_st += int'(stall);
            n_b  += int'(mdu_busy);
            advance();
        end
        chk("mdu_stall_cycles", n_st, MDU ? DIV_CYC : 0);
        chk("mdu_busy_cycles", n_b, MDU ? DIV_CYC : 0);
        idle(3);

        // reset with hazard pending
        put(1, 0, 3, 0, 3, 2, 2);
        settle(); advance();
        put(1, 2, 0, 0, 3, 0, 0);
        reset = 1'b1;
        settle(); chk("rst_mid_stall", stall, 0); advance();
        put(1, 2, 0, 0, 3, 0, 0);
        settle(); chk("rst_after_stall", stall, 0);
        chk("rst_after_sel", fwd_rs_sel, 0); advance();

        repeat (600) begin
            put($urandom_range(0, 9) != 0,
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
            d_md      = ($urandom_range(0, 15) == 0);
            d_md_div  = $urandom_range(0, 1) == 1;
            d_mdu_use = d_md | ($urandom_range(0, 5) == 0);
            flush     = ($urandom_range(0, 30) == 0);
            reset     = ($urandom_range(0, 60) == 0);
            settle();
            advance();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
